uart_fifo_link: RTL and testbench
=================================

Name: uart_fifo_link

Overview:
Parametrised full-duplex UART transceiver with TX and RX FIFOs. It replaces the bare uart_receive/uart_transmit pair feeding the UCI handler. Byte streams cross in both directions with valid/ready handshakes, so the UCI handler and engine can burst data without losing characters. It adds configurable frame width, glitch-rejecting start detection, sticky framing/overflow status and occupancy counts.

Parameters:
INPUT_CLOCK_FREQ, 40_000_000, clk_in frequency in Hz
BAUD_RATE, 115200, line rate; BAUD_DIV = INPUT_CLOCK_FREQ/BAUD_RATE (integer division, must be >= 4)
DATA_BITS, 8, payload bits per frame (5..9)
FIFO_DEPTH, 16, entries per FIFO; power of two, >= 2

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
rx_wire_in  input  1  serial line in, idle high
tx_wire_out  output  1  serial line out, idle high
tx_data_in  input  DATA_BITS  byte to send
tx_valid_in  input  1  tx_data_in valid
tx_ready_out  output  1  TX FIFO not full
rx_data_out  output  DATA_BITS  head of RX FIFO (first-word fall-through)
rx_valid_out  output  1  RX FIFO not empty
rx_ready_in  input  1  consumer accepts rx_data_out
tx_count_out  output  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
rx_count_out  output  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
rx_overflow_out  output  1  sticky: received frame dropped, RX FIFO full
rx_frame_err_out  output  1  sticky: stop bit sampled low
clear_err_in  input  1  clears both sticky flags

Behaviour:
- Reset (rst_in=0, async): tx_wire_out=1, tx_ready_out=1, rx_valid_out=0, rx_data_out=0, counts=0, sticky flags=0, both FSMs IDLE, synchroniser flops=1.
- Transfers: TX push on tx_valid_in&tx_ready_out. RX pop on rx_valid_out&rx_ready_in. Counts update on the following edge.
- tx_ready_out = !tx_full (registered). No push-when-full bypass.
- RX FIFO accepts a write when not full, or when full with a pop in the same cycle.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. Each bit is held exactly BAUD_DIV cycles, LSB first. Start bit = 0, stop bit = 1.
- TX pops its FIFO on the IDLE->START edge. tx_wire_out falls on the cycle after a push into an empty FIFO with FSM IDLE: push edge N, line low from edge N+1.
- TX back-to-back frames: after STOP, if the FIFO is non-empty, go straight to START with no extra idle cycles.
- RX input: 2-flop synchroniser. RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP.
- RX IDLE: a synchronised low starts the frame. At BAUD_DIV/2 cycles the line is resampled; if high (glitch), return to IDLE with no flag set.
- RX then samples each bit at BAUD_DIV intervals (mid-bit).
- RX STOP sample high: write the byte. If the write is refused (full, no pop), discard the frame and set rx_overflow_out.
- RX STOP sample low: set rx_frame_err_out, discard the frame, enter WAIT_IDLE until the line is high, then IDLE.
- clear_err_in=1 clears the sticky flags next edge; a same-cycle error event wins (flag stays 1).
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; full/empty come from occupancy count.
- Reset asserted mid-frame aborts both directions immediately; partial RX frame lost.

Optional Feature:
UART_LINK_PARITY_EN
- Defined: one even-parity bit is inserted after the data bits (TX) and checked (RX). An RX parity mismatch discards the frame and sets rx_frame_err_out.
- Undefined: no parity state, 1+DATA_BITS+1 bit frames; PARITY states absent.

Test Plan:
- TX frame (INPUT_CLOCK_FREQ=16, BAUD_RATE=1, BAUD_DIV=16): push 0xA5 into idle link -> tx_wire_out 0,1,0,1,0,0,1,0,1,1, each 16 cycles, starting edge after push; tx_count_out 1 -> 0 at frame start.
- Loopback (tx_wire_out->rx_wire_in), rx_ready_in=0: push 0x00..0x10 (17 bytes) -> rx_count_out=16, rx_data_out=0x00, rx_overflow_out=1 after 17th frame; draining yields 0x00..0x0F in order.
- Framing: drive start, 0x3C LSB-first, stop=0 -> rx_frame_err_out=1, rx_count_out=0; pulse clear_err_in -> 0 next edge.
- Glitch: rx_wire_in low 4 cycles (BAUD_DIV=16) -> no FSM exit from IDLE after midpoint, no byte, no flags.
- Back-pressure: tx_valid_in held 1 with 20 bytes 0x40..0x53 -> tx_ready_out drops when tx_count_out=16, no byte lost, wire order 0x40..0x53 with no inter-frame idle.
- Reset mid-frame: drop rst_in during TX data bit 3 -> tx_wire_out=1 same cycle, counts 0, rx_valid_out 0; with UART_LINK_PARITY_EN, loopback 0x07 sends parity bit 1 and RX flags a corrupted parity bit.

Source files
------------

// File: rtl/uart_fifo_link.sv
// Full-duplex UART with TX/RX FIFOs, glitch-rejecting start detect and sticky status.
// Optional even parity bit when UART_LINK_PARITY_EN is defined.
module uart_fifo_link #(
    parameter int INPUT_CLOCK_FREQ = 40_000_000,
    parameter int BAUD_RATE        = 115200,
    parameter int DATA_BITS        = 8,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rx_wire_in,
    output logic                        tx_wire_out,
    input  logic [DATA_BITS-1:0]        tx_data_in,
    input  logic                        tx_valid_in,
    output logic                        tx_ready_out,
    output logic [DATA_BITS-1:0]        rx_data_out,
    output logic                        rx_valid_out,
    input  logic                        rx_ready_in,
    output logic [$clog2(FIFO_DEPTH):0] tx_count_out,
    output logic [$clog2(FIFO_DEPTH):0] rx_count_out,
    output logic                        rx_overflow_out,
    output logic                        rx_frame_err_out,
    input  logic                        clear_err_in
);

    localparam int BAUD_DIV = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int BAUD_W   = $clog2(BAUD_DIV);
    localparam int BIT_W    = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_DIV / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------ TX FIFO
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     tx_wptr, tx_rptr;
    logic [CNT_W-1:0]     tx_count, tx_count_nxt;
    logic                 tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_push      = tx_valid_in & tx_ready_out;
    assign tx_count_nxt = tx_count + CNT_W'(tx_push) - CNT_W'(tx_pop);
    assign tx_head      = tx_mem[tx_rptr];
    assign tx_count_out = tx_count;

    // NOTE: FIFO storage has no reset; pointers and counts alone define validity.
    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wptr] <= tx_data_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wptr      <= '0;
            tx_rptr      <= '0;
            tx_count     <= '0;
            tx_ready_out <= 1'b1;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PTR_W'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_W'(1);
            tx_count     <= tx_count_nxt;
            tx_ready_out <= (tx_count_nxt != FULL_CNT);
        end
    end

    // ------------------------------------------------------------------ TX FSM
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_LINK_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    tx_state_t            tx_state, tx_state_nxt;
    logic [BAUD_W-1:0]    tx_baud, tx_baud_nxt;
    logic [BIT_W-1:0]     tx_bit, tx_bit_nxt;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
    logic                 tx_line_nxt, tx_done, tx_load;
`ifdef UART_LINK_PARITY_EN
    logic                 tx_par, tx_par_nxt;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_baud_nxt  = tx_baud;
        tx_bit_nxt   = tx_bit;
        tx_shift_nxt = tx_shift;
`ifdef UART_LINK_PARITY_EN
        tx_par_nxt   = tx_par;
`endif
        tx_pop       = 1'b0;
        tx_load      = 1'b0;
        tx_done      = (tx_baud == BAUD_LAST);

        if (tx_state != TX_IDLE) tx_baud_nxt = tx_done ? '0 : tx_baud + BAUD_W'(1);

        case (tx_state)
            TX_IDLE:  tx_load = (tx_count != '0);
            TX_START: if (tx_done) begin
                tx_state_nxt = TX_DATA;
                tx_bit_nxt   = '0;
            end
            TX_DATA: if (tx_done) begin
                if (tx_bit == BIT_LAST) begin
`ifdef UART_LINK_PARITY_EN
                    tx_state_nxt = TX_PARITY;
`else
                    tx_state_nxt = TX_STOP;
`endif
                end else begin
                    tx_shift_nxt = tx_shift >> 1;
                    tx_bit_nxt   = tx_bit + BIT_W'(1);
                end
            end
`ifdef UART_LINK_PARITY_EN
            TX_PARITY: if (tx_done) tx_state_nxt = TX_STOP;
`endif
            TX_STOP: if (tx_done) begin
                // Chain straight into the next start bit when more data is queued.
                if (tx_count != '0) tx_load = 1'b1;
                else                tx_state_nxt = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase

        if (tx_load) begin
            tx_pop       = 1'b1;
            tx_state_nxt = TX_START;
            tx_baud_nxt  = '0;
            tx_shift_nxt = tx_head;
`ifdef UART_LINK_PARITY_EN
            tx_par_nxt   = ^tx_head;
`endif
        end

        case (tx_state_nxt)
            TX_START:  tx_line_nxt = 1'b0;
            TX_DATA:   tx_line_nxt = tx_shift_nxt[0];
`ifdef UART_LINK_PARITY_EN
            TX_PARITY: tx_line_nxt = tx_par_nxt;
`endif
            default:   tx_line_nxt = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_state    <= TX_IDLE;
            tx_baud     <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            tx_wire_out <= 1'b1;
`ifdef UART_LINK_PARITY_EN
            tx_par      <= 1'b0;
`endif
        end else begin
            tx_state    <= tx_state_nxt;
            tx_baud     <= tx_baud_nxt;
            tx_bit      <= tx_bit_nxt;
            tx_shift    <= tx_shift_nxt;
            tx_wire_out <= tx_line_nxt;
`ifdef UART_LINK_PARITY_EN
            tx_par      <= tx_par_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------ RX FIFO
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rx_wptr, rx_rptr;
    logic [CNT_W-1:0]     rx_count;
    logic                 rx_pop, rx_wr, rx_accept, rx_set_ovf, rx_set_ferr;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;

    assign rx_valid_out = (rx_count != '0);
    assign rx_data_out  = rx_valid_out ? rx_mem[rx_rptr] : '0;
    assign rx_pop       = rx_valid_out & rx_ready_in;
    assign rx_accept    = rx_wr & ((rx_count != FULL_CNT) | rx_pop);
    assign rx_set_ovf   = rx_wr & ~rx_accept;
    assign rx_count_out = rx_count;

    always_ff @(posedge clk_in) begin
        if (rx_accept) rx_mem[rx_wptr] <= rx_shift;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_wptr          <= '0;
            rx_rptr          <= '0;
            rx_count         <= '0;
            rx_overflow_out  <= 1'b0;
            rx_frame_err_out <= 1'b0;
        end else begin
            if (rx_accept) rx_wptr <= rx_wptr + PTR_W'(1);
            if (rx_pop)    rx_rptr <= rx_rptr + PTR_W'(1);
            rx_count         <= rx_count + CNT_W'(rx_accept) - CNT_W'(rx_pop);
            // A set in the same cycle as a clear keeps the flag raised.
            rx_overflow_out  <= rx_set_ovf  | (rx_overflow_out  & ~clear_err_in);
            rx_frame_err_out <= rx_set_ferr | (rx_frame_err_out & ~clear_err_in);
        end
    end

    // ------------------------------------------------------------------ RX FSM
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_LINK_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    rx_state_t         rx_state, rx_state_nxt;
    logic [1:0]        rx_sync;
    logic              rx_s, rx_done;
    logic [BAUD_W-1:0] rx_baud, rx_baud_nxt;
    logic [BIT_W-1:0]  rx_bit, rx_bit_nxt;
`ifdef UART_LINK_PARITY_EN
    logic              rx_par_ok, rx_par_ok_nxt;
`endif

    assign rx_s = rx_sync[1];

    always_comb begin
        rx_state_nxt  = rx_state;
        rx_baud_nxt   = rx_baud;
        rx_bit_nxt    = rx_bit;
        rx_shift_nxt  = rx_shift;
`ifdef UART_LINK_PARITY_EN
        rx_par_ok_nxt = rx_par_ok;
`endif
        rx_wr         = 1'b0;
        rx_set_ferr   = 1'b0;
        rx_done       = (rx_baud == BAUD_LAST);

        if (rx_state != RX_IDLE && rx_state != RX_WAIT_IDLE)
            rx_baud_nxt = rx_done ? '0 : rx_baud + BAUD_W'(1);

        case (rx_state)
            RX_IDLE: if (!rx_s) begin
                rx_state_nxt = RX_START;
                rx_baud_nxt  = '0;
            end
            RX_START: if (rx_baud == HALF_LAST) begin
                // Mid start bit: a line back high was only a glitch.
                rx_baud_nxt  = '0;
                rx_bit_nxt   = '0;
                rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_done) begin
                rx_shift_nxt = {rx_s, rx_shift[DATA_BITS-1:1]};
                if (rx_bit == BIT_LAST) begin
`ifdef UART_LINK_PARITY_EN
                    rx_state_nxt = RX_PARITY;
`else
                    rx_state_nxt = RX_STOP;
`endif
                end else begin
                    rx_bit_nxt = rx_bit + BIT_W'(1);
                end
            end
`ifdef UART_LINK_PARITY_EN
            RX_PARITY: if (rx_done) begin
                rx_par_ok_nxt = (rx_s == ^rx_shift);
                rx_state_nxt  = RX_STOP;
            end
`endif
            RX_STOP: if (rx_done) begin
                if (rx_s) begin
                    rx_state_nxt = RX_IDLE;
`ifdef UART_LINK_PARITY_EN
                    if (rx_par_ok) rx_wr = 1'b1;
                    else           rx_set_ferr = 1'b1;
`else
                    rx_wr = 1'b1;
`endif
                end else begin
                    rx_set_ferr  = 1'b1;
                    rx_state_nxt = RX_WAIT_IDLE;
                end
            end
            RX_WAIT_IDLE: if (rx_s) rx_state_nxt = RX_IDLE;
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_sync   <= 2'b11;
            rx_state  <= RX_IDLE;
            rx_baud   <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
`ifdef UART_LINK_PARITY_EN
            rx_par_ok <= 1'b1;
`endif
        end else begin
            rx_sync   <= {rx_sync[0], rx_wire_in};
            rx_state  <= rx_state_nxt;
            rx_baud   <= rx_baud_nxt;
            rx_bit    <= rx_bit_nxt;
            rx_shift  <= rx_shift_nxt;
`ifdef UART_LINK_PARITY_EN
            rx_par_ok <= rx_par_ok_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_fifo_link.sv
// Directed bench for uart_fifo_link at BAUD_DIV=16; parity scenario builds with UART_LINK_PARITY_EN.
module tb_uart_fifo_link;

    localparam int BD = 16;
`ifdef UART_LINK_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       rx_wire_in;
    logic       tx_wire_out;
    logic [7:0] tx_data_in = '0;
    logic       tx_valid_in = 1'b0;
    logic       tx_ready_out;
    logic [7:0] rx_data_out;
    logic       rx_valid_out;
    logic       rx_ready_in = 1'b0;
    logic [4:0] tx_count_out;
    logic [4:0] rx_count_out;
    logic       rx_overflow_out;
    logic       rx_frame_err_out;
    logic       clear_err_in = 1'b0;

    logic       loopback = 1'b0;
    logic       rx_drive = 1'b1;
    int         errors = 0;
    int         checks = 0;

    assign rx_wire_in = loopback ? tx_wire_out : rx_drive;

    always #5 clk_in = ~clk_in;

    uart_fifo_link #(
        .INPUT_CLOCK_FREQ(16),
        .BAUD_RATE       (1),
        .DATA_BITS       (8),
        .FIFO_DEPTH      (16)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rx_wire_in      (rx_wire_in),
        .tx_wire_out     (tx_wire_out),
        .tx_data_in      (tx_data_in),
        .tx_valid_in     (tx_valid_in),
        .tx_ready_out    (tx_ready_out),
        .rx_data_out     (rx_data_out),
        .rx_valid_out    (rx_valid_out),
        .rx_ready_in     (rx_ready_in),
        .tx_count_out    (tx_count_out),
        .rx_count_out    (rx_count_out),
        .rx_overflow_out (rx_overflow_out),
        .rx_frame_err_out(rx_frame_err_out),
        .clear_err_in    (clear_err_in)
    );

    // Expected line level of bit i of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
`ifdef UART_LINK_PARITY_EN
        if (i == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic push_byte(input logic [7:0] d);
        int n = 0;
        @(negedge clk_in);
        tx_data_in  = d;
        tx_valid_in = 1'b1;
        while (!tx_ready_out && n < 1000) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (tx_ready_out !== 1'b1) begin
            errors++;
            $display("FAIL push_wait: tx_ready_out=%b required 1", tx_ready_out);
        end
        @(posedge clk_in);
        #1 tx_valid_in = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk_in);
        rx_ready_in = 1'b1;
        @(posedge clk_in);
        #1 rx_ready_in = 1'b0;
    endtask

    task automatic clear_flags();
        @(negedge clk_in);
        clear_err_in = 1'b1;
        @(negedge clk_in);
        clear_err_in = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
        @(negedge clk_in);
        for (int i = 0; i < FB; i++) begin
            rx_drive = frame_bit(d, i);
`ifdef UART_LINK_PARITY_EN
            if (i == 9) rx_drive = frame_bit(d, i) ^ flip;
`endif
            if (i == FB - 1) rx_drive = stop;
            repeat (BD) @(negedge clk_in);
        end
        rx_drive = 1'b1;
    endtask

    task automatic wait_line_low(output logic seen);
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(posedge clk_in);
            #1 seen = (tx_wire_out == 1'b0);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_in);
        if (tx_wire_out !== 1'b1)      begin errors++; $display("FAIL rst_tx_wire: got %b want 1", tx_wire_out); end
        if (tx_ready_out !== 1'b1)     begin errors++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready_out); end
        if (rx_valid_out !== 1'b0)     begin errors++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid_out); end
        if (rx_data_out !== 8'h00)     begin errors++; $display("FAIL rst_rx_data: got %h want 00", rx_data_out); end
        if (tx_count_out !== 5'd0)     begin errors++; $display("FAIL rst_tx_count: got %0d want 0", tx_count_out); end
        if (rx_count_out !== 5'd0)     begin errors++; $display("FAIL rst_rx_count: got %0d want 0", rx_count_out); end
        if ({rx_overflow_out, rx_frame_err_out} !== 2'b00) begin
            errors++; $display("FAIL rst_flags: got %b want 00", {rx_overflow_out, rx_frame_err_out});
        end
        checks += 7;
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_tx_frame();
        int bad;
        @(negedge clk_in);
        tx_data_in  = 8'hA5;
        tx_valid_in = 1'b1;
        @(posedge clk_in);
        #1 tx_valid_in = 1'b0;
        checks += 2;
        if (tx_count_out !== 5'd1) begin errors++; $display("FAIL txf_count_after_push: got %0d want 1", tx_count_out); end
        if (tx_wire_out !== 1'b1)  begin errors++; $display("FAIL txf_line_at_push: got %b want 1", tx_wire_out); end
        for (int b = 0; b < FB; b++) begin
            bad = 0;
            for (int c = 0; c < BD; c++) begin
                @(posedge clk_in);
                #1;
                if (b == 0 && c == 0) begin
                    checks++;
                    if (tx_count_out !== 5'd0) begin errors++; $display("FAIL txf_count_at_start: got %0d want 0", tx_count_out); end
                end
                if (tx_wire_out !== frame_bit(8'hA5, b)) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL txf_bit%0d: %0d of %0d cycles differ from %b", b, bad, BD, frame_bit(8'hA5, b));
            end
        end
    endtask

    task automatic test_loopback_overflow();
        int n;
        loopback    = 1'b1;
        rx_ready_in = 1'b0;
        for (int i = 0; i <= 16; i++) push_byte(8'(i));
        n = 0;
        while (!rx_overflow_out && n < 5000) begin
            @(posedge clk_in);
            #1 n++;
        end
        checks += 4;
        if (rx_overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", rx_overflow_out); end
        if (rx_count_out !== 5'd16)   begin errors++; $display("FAIL ovf_rx_count: got %0d want 16", rx_count_out); end
        if (rx_data_out !== 8'h00)    begin errors++; $display("FAIL ovf_head: got %h want 00", rx_data_out); end
        if (rx_frame_err_out !== 1'b0) begin errors++; $display("FAIL ovf_no_ferr: got %b want 0", rx_frame_err_out); end
        repeat (20) @(negedge clk_in);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_in);
            checks++;
            if (rx_valid_out !== 1'b1 || rx_data_out !== 8'(i)) begin
                errors++;
                $display("FAIL drain_%0d: got valid=%b data=%h want valid=1 data=%h", i, rx_valid_out, rx_data_out, 8'(i));
            end
            pop_one();
        end
        checks++;
        if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", rx_valid_out); end
        @(negedge clk_in);
        clear_err_in = 1'b1;
        @(posedge clk_in);
        #1 checks++;
        if (rx_overflow_out !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", rx_overflow_out); end
        clear_err_in = 1'b0;
        loopback = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  idx = 0;
        int  guard = 0;
        int  rdy_bad = 0;
        bit  saw_full = 0;
        int  bad [20];
        logic rdy, seen;
        foreach (bad[k]) bad[k] = 0;
        fork
            begin
                while (idx < 20 && guard < 5000) begin
                    @(negedge clk_in);
                    tx_data_in  = 8'(8'h40 + idx);
                    tx_valid_in = 1'b1;
                    rdy = tx_ready_out;
                    if (tx_ready_out !== (tx_count_out != 5'd16)) rdy_bad++;
                    if (tx_count_out == 5'd16 && tx_ready_out == 1'b0) saw_full = 1;
                    @(posedge clk_in);
                    #1 guard++;
                    if (rdy) idx++;
                end
                tx_valid_in = 1'b0;
            end
            begin
                wait_line_low(seen);
                for (int s = 0; s < 20 * FB * BD; s++) begin
                    if (s != 0) begin
                        @(posedge clk_in);
                        #1;
                    end
                    if (tx_wire_out !== frame_bit(8'(8'h40 + s / (FB * BD)), (s / BD) % FB)) bad[s / (FB * BD)]++;
                end
                if (!seen) bad[0]++;
            end
        join
        checks += 2;
        if (!saw_full || rdy_bad != 0) begin
            errors++; $display("FAIL b2b_ready: saw_full=%0d ready_vs_count_errs=%0d want 1/0", saw_full, rdy_bad);
        end
        if (idx != 20) begin errors++; $display("FAIL b2b_pushes: got %0d want 20", idx); end
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (bad[k] != 0) begin
                errors++; $display("FAIL b2b_frame_%h: %0d line samples wrong", 8'(8'h40 + k), bad[k]);
            end
        end
    endtask

    task automatic test_framing();
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge clk_in);
        checks += 3;
        if (rx_frame_err_out !== 1'b1) begin errors++; $display("FAIL frm_flag: got %b want 1", rx_frame_err_out); end
        if (rx_count_out !== 5'd0)     begin errors++; $display("FAIL frm_count: got %0d want 0", rx_count_out); end
        if (rx_overflow_out !== 1'b0)  begin errors++; $display("FAIL frm_no_ovf: got %b want 0", rx_overflow_out); end
        @(negedge clk_in);
        clear_err_in = 1'b1;
        @(posedge clk_in);
        #1 checks++;
        if (rx_frame_err_out !== 1'b0) begin errors++; $display("FAIL frm_clear: got %b want 0", rx_frame_err_out); end
        clear_err_in = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (20) @(negedge clk_in);
        checks += 2;
        if (rx_count_out !== 5'd1 || rx_data_out !== 8'h3C) begin
            errors++; $display("FAIL frm_recover: got count=%0d data=%h want 1/3c", rx_count_out, rx_data_out);
        end
        if (rx_frame_err_out !== 1'b0) begin errors++; $display("FAIL frm_good_no_ferr: got %b want 0", rx_frame_err_out); end
        pop_one();
    endtask

    task automatic test_glitch();
        @(negedge clk_in);
        rx_drive = 1'b0;
        repeat (4) @(negedge clk_in);
        rx_drive = 1'b1;
        repeat (200) @(negedge clk_in);
        checks += 2;
        if (rx_count_out !== 5'd0) begin errors++; $display("FAIL glitch_count: got %0d want 0", rx_count_out); end
        if ({rx_overflow_out, rx_frame_err_out} !== 2'b00) begin
            errors++; $display("FAIL glitch_flags: got %b want 00", {rx_overflow_out, rx_frame_err_out});
        end
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (20) @(negedge clk_in);
        checks++;
        if (rx_count_out !== 5'd1 || rx_data_out !== 8'h81) begin
            errors++; $display("FAIL glitch_then_frame: got count=%0d data=%h want 1/81", rx_count_out, rx_data_out);
        end
        pop_one();
    endtask

`ifdef UART_LINK_PARITY_EN
    task automatic test_parity();
        logic seen;
        int   n = 0;
        loopback = 1'b1;
        push_byte(8'h07);
        wait_line_low(seen);
        repeat (9 * BD + 8) @(posedge clk_in);
        #1 checks++;
        if (!seen || tx_wire_out !== 1'b1) begin
            errors++; $display("FAIL par_tx_bit: got %b want 1", tx_wire_out);
        end
        while (!rx_valid_out && n < 400) begin
            @(posedge clk_in);
            #1 n++;
        end
        checks++;
        if (rx_data_out !== 8'h07 || rx_frame_err_out !== 1'b0) begin
            errors++; $display("FAIL par_loop: got data=%h ferr=%b want 07/0", rx_data_out, rx_frame_err_out);
        end
        pop_one();
        repeat (20) @(negedge clk_in);
        loopback = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (20) @(negedge clk_in);
        checks++;
        if (rx_frame_err_out !== 1'b1 || rx_count_out !== 5'd0) begin
            errors++; $display("FAIL par_bad: got ferr=%b count=%0d want 1/0", rx_frame_err_out, rx_count_out);
        end
        clear_flags();
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic seen;
        int   n = 0;
        loopback    = 1'b1;
        rx_ready_in = 1'b0;
        push_byte(8'h11);
        while (!rx_valid_out && n < 400) begin
            @(posedge clk_in);
            #1 n++;
        end
        push_byte(8'hF0);
        push_byte(8'h22);
        wait_line_low(seen);
        repeat (70) @(posedge clk_in);
        #1 checks++;
        if (!seen || tx_wire_out !== 1'b0 || rx_valid_out !== 1'b1 || tx_count_out !== 5'd1) begin
            errors++;
            $display("FAIL rmf_before: got line=%b rx_valid=%b tx_count=%0d want 0/1/1", tx_wire_out, rx_valid_out, tx_count_out);
        end
        #1 rst_in = 1'b0;
        #1 checks += 4;
        if (tx_wire_out !== 1'b1)  begin errors++; $display("FAIL rmf_line: got %b want 1", tx_wire_out); end
        if (tx_count_out !== 5'd0 || rx_count_out !== 5'd0) begin
            errors++; $display("FAIL rmf_counts: got tx=%0d rx=%0d want 0/0", tx_count_out, rx_count_out);
        end
        if (rx_valid_out !== 1'b0) begin errors++; $display("FAIL rmf_rx_valid: got %b want 0", rx_valid_out); end
        if (tx_ready_out !== 1'b1) begin errors++; $display("FAIL rmf_tx_ready: got %b want 1", tx_ready_out); end
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (400) @(negedge clk_in);
        checks++;
        if (rx_count_out !== 5'd0 || tx_wire_out !== 1'b1 || rx_frame_err_out !== 1'b0) begin
            errors++;
            $display("FAIL rmf_after: got rx_count=%0d line=%b ferr=%b want 0/1/0", rx_count_out, tx_wire_out, rx_frame_err_out);
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback_overflow();
        test_back_to_back();
        test_framing();
        test_glitch();
`ifdef UART_LINK_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
